// File: rtl/adc_delay_calibration.sv
`timescale 1ns/1ps
// Per-channel ADC ramp checker that steers an input delay line.
// FIRST_PASS stops on the first good tap; CENTER parks mid widest window.
module adc_delay_calibration #(
  parameter  int CHANNELS   = 2,
  parameter  int WIDTH      = 14,
  parameter  int SETTLE     = 4,
  parameter  int PASS_COUNT = 2000,
  parameter  int MAX_TAPS   = 32,
  parameter  int CENTER     = 1,
  localparam int TAP_W      = $clog2(MAX_TAPS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [CHANNELS*WIDTH-1:0] i_adc,
  output logic [CHANNELS-1:0]       o_ce,
  output logic [CHANNELS-1:0]       o_inc,
  output logic [CHANNELS*TAP_W-1:0] o_tap,
  output logic [CHANNELS-1:0]       o_fail,
  output logic                      o_done,
  output logic                      o_busy
);

  localparam int CNT_MAX = (SETTLE > PASS_COUNT) ? SETTLE : PASS_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LEN_W   = $clog2(MAX_TAPS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CHECK, S_STEP,
    S_SCAN_END, S_MOVE, S_DONE, S_FAIL
  } state_t;

  logic [CHANNELS-1:0] w_idle;
  logic [CHANNELS-1:0] w_fin;
  logic [CHANNELS-1:0] w_act;
  logic                w_go;
  logic                r_done;

  assign w_go   = i_start & (&w_idle);
  assign o_busy = |w_act;
  assign o_done = r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_done <= 1'b0;
    else       r_done <= &w_fin;
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_buf;
    logic [WIDTH-1:0]   r_prev;
    logic [CNT_W-1:0]   r_cnt;
    logic [TAP_W-1:0]   r_tap;
    logic [TAP_W-1:0]   r_target;
    logic [TAP_W-1:0]   r_run_start;
    logic [TAP_W-1:0]   r_best_start;
    logic [LEN_W-1:0]   r_run_len;
    logic [LEN_W-1:0]   r_best_len;
    logic               w_good;
    logic               w_last;
    logic               w_pass;
    logic               w_miss;
    logic               w_close;
    logic               w_pulse;
    logic [TAP_W-1:0]   w_bs;
    logic [LEN_W-1:0]   w_bl;
    logic [TAP_W-1:0]   w_target;

    assign w_good  = (r_buf == r_prev + WIDTH'(1));
    assign w_last  = (r_tap == TAP_W'(MAX_TAPS - 1));
    assign w_pass  = (r_state == S_CHECK) && w_good &&
                     (r_cnt == CNT_W'(PASS_COUNT - 1));
    assign w_miss  = (r_state == S_CHECK) && !w_good;
    assign w_close = (r_run_len > r_best_len);
    assign w_bs    = w_close ? r_run_start : r_best_start;
    assign w_bl    = w_close ? r_run_len : r_best_len;
    assign w_target = w_bs + TAP_W'(w_bl >> 1);
    // MOVE uses cnt[0] as phase: 0 = pulse slot, 1 = gap
    assign w_pulse = (r_state == S_MOVE) && !r_cnt[0] &&
                     (r_tap != r_target);

    always_comb begin
      w_next = r_state;
      unique case (r_state)
        S_IDLE:     if (w_go) w_next = S_SETTLE;
        S_SETTLE:   if (r_cnt == CNT_W'(SETTLE - 1)) w_next = S_CHECK;
        S_CHECK: begin
          if (w_pass || w_miss) begin
            if (CENTER != 0) w_next = w_last ? S_SCAN_END : S_STEP;
            else if (w_pass) w_next = S_DONE;
            else             w_next = w_last ? S_FAIL : S_STEP;
          end
        end
        S_STEP:     w_next = S_SETTLE;
        S_SCAN_END: w_next = (w_bl == '0) ? S_FAIL : S_MOVE;
        S_MOVE:     if (!r_cnt[0] && r_tap == r_target) w_next = S_DONE;
        S_DONE:     w_next = S_DONE;
        S_FAIL:     w_next = S_FAIL;
        default:    w_next = S_IDLE;
      endcase
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_state      <= S_IDLE;
        r_buf        <= '0;
        r_prev       <= '0;
        r_cnt        <= '0;
        r_tap        <= '0;
        r_target     <= '0;
        r_run_start  <= '0;
        r_best_start <= '0;
        r_run_len    <= '0;
        r_best_len   <= '0;
      end else begin
        r_state <= w_next;
        r_buf   <= i_adc[k*WIDTH +: WIDTH];
        r_prev  <= r_buf;
        if (w_next != r_state)      r_cnt <= '0;
        else if (r_state == S_MOVE) r_cnt <= r_cnt ^ CNT_W'(1);
        else                        r_cnt <= r_cnt + CNT_W'(1);
        if (r_state == S_STEP) r_tap <= r_tap + TAP_W'(1);
        else if (w_pulse)      r_tap <= r_tap - TAP_W'(1);
        if (CENTER != 0 && w_pass) begin
          if (r_run_len == '0) r_run_start <= r_tap;
          r_run_len <= r_run_len + LEN_W'(1);
        end else if (CENTER != 0 && w_miss) begin
          if (w_close) begin
            r_best_start <= r_run_start;
            r_best_len   <= r_run_len;
          end
          r_run_len <= '0;
        end
        if (r_state == S_SCAN_END) begin
          r_target     <= w_target;
          r_best_start <= w_bs;
          r_best_len   <= w_bl;
          r_run_len    <= '0;
        end
      end
    end

    assign o_ce[k]  = (r_state == S_STEP) | w_pulse;
    assign o_inc[k] = (r_state == S_STEP);
    assign o_tap[k*TAP_W +: TAP_W] = r_tap;
    assign o_fail[k] = (r_state == S_FAIL);
    assign w_idle[k] = (r_state == S_IDLE);
    assign w_fin[k]  = (r_state == S_DONE) || (r_state == S_FAIL);
    assign w_act[k]  = !w_idle[k] && !w_fin[k];
  end

endmodule
